serial_adder: RTL and testbench

- Bit-serial full adder, the additive counterpart of the team's combinational full subtractor.
- Accepts two WIDTH-bit operands plus carry-in on a start strobe and processes one bit per clock, LSB first, through a single full-adder cell and a carry flop.
- Returns a WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake/data bundle for the bit-serial adder: operands and strobe in,
// status and registered result out.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// producing {cout,sum} = a + b + cin after WIDTH RUN cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (ci & (x ^ y));
    endfunction

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] r;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] r_full;

    assign s_bit  = fa_sum(sa[0], sb[0], c);
    assign c_next = fa_carry(sa[0], sb[0], c);
    // Result bits enter at the MSB; after WIDTH shifts r_full is the whole sum.
    assign r_full = {s_bit, r};

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            r      <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        c      <= bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= c_next;
                    r   <= r_full[WIDTH-1:1];
                    cnt <= cnt + 1'b1;
                    // Terminal bit: publish the result including this cycle's bit and carry.
                    if (cnt == LAST) begin
                        sum_q  <= r_full;
                        cout_q <= c_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8) with a queue scoreboard of
// expected {cout,sum} values pushed at launch and popped at done.
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [W:0] sb_q[$];
    logic [W:0] prev_res;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a start at the current negedge; it is accepted at the next posedge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input bit push);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = ci;
        if (push) sb_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
    endtask

    // Wait (bounded) for done; optionally inject a stray start at RUN cycle inj.
    task automatic wait_done(input string tag, input int inj);
        int         n;
        int         busy_n;
        bit         seen;
        bit         hold_ok;
        bit         excl_ok;
        logic [W:0] exp;
        n = 0; busy_n = 0; seen = 0; hold_ok = 1; excl_ok = 1;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.busy && bus.done) excl_ok = 0;
            if (bus.busy) busy_n++;
            if (bus.done) seen = 1;
            else if ({bus.cout, bus.sum} !== prev_res) hold_ok = 0;
            if (n == inj) begin
                bus.start = 1'b1; bus.a = '1; bus.b = '1; bus.cin = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(W + 1));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
        check({tag, "_hold_prev"}, 32'(hold_ok), 32'd1);
        check({tag, "_busy_done_excl"}, 32'(excl_ok), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_nonempty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_sum"}, 32'(bus.sum), 32'(exp[W-1:0]));
            check({tag, "_cout"}, 32'(bus.cout), 32'(exp[W]));
            prev_res = exp;
        end
    endtask

    // Watch n cycles with start low: no further done, idle.
    task automatic quiet(input string tag, input int ncyc);
        int dn;
        int bn;
        dn = 0; bn = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.busy) bn++;
        end
        check({tag, "_extra_done"}, 32'(dn), 32'd0);
        check({tag, "_idle_busy"}, 32'(bn), 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0;
        prev_res = '0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: zero operands
        launch(8'h00, 8'h00, 1'b0, 1);
        wait_done("t1_zero", 0);
        quiet("t1", 2);

        // 2: carry out of the top, then carry-in used
        launch(8'hFF, 8'h01, 1'b0, 1);
        wait_done("t2_ff01", 0);
        quiet("t2a", 1);
        launch(8'h3C, 8'h42, 1'b1, 1);
        wait_done("t2_3c42", 0);
        quiet("t2b", 1);

        // 3: full ripple, previous result must hold during RUN
        launch(8'hA5, 8'h5A, 1'b1, 1);
        wait_done("t3_ripple", 0);
        quiet("t3", 1);

        // 4: stray start at RUN cycle 3 is ignored
        launch(8'h10, 8'h20, 1'b0, 1);
        wait_done("t4_ignore", 3);
        quiet("t4", 12);

        // 5: back-to-back start in the DONE cycle
        launch(8'h11, 8'h22, 1'b0, 1);
        wait_done("t5_first", 0);
        launch(8'h80, 8'h80, 1'b0, 1);
        wait_done("t5_b2b", 0);
        quiet("t5", 1);

        // 6: asynchronous reset mid-RUN aborts without a done pulse
        launch(8'h55, 8'h33, 1'b0, 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_abort_busy", 32'(bus.busy), 32'd0);
        check("t6_abort_done", 32'(bus.done), 32'd0);
        check("t6_abort_sum", 32'(bus.sum), 32'd0);
        check("t6_abort_cout", 32'(bus.cout), 32'd0);
        prev_res = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet("t6_post_reset", 12);
        launch(8'h01, 8'h02, 1'b0, 1);
        wait_done("t6_after", 0);
        quiet("t6", 1);

        // Extra randomized operations, alternately back-to-back
        for (int i = 0; i < 6; i++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom), 1);
            wait_done("rnd", 0);
            if (i[0]) quiet("rnd", 1);
        end
        quiet("end", 2);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
